// File: rtl/priority_arb_2bit_pkg.sv
// Shared types and helpers for the two-requester fixed-priority arbiter.
package priority_arb_2bit_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic logic onehot_to_idx(input req_vec_t v);
        logic idx;
        idx = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (v[i]) idx = 1'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_arb_2bit_pick.sv
// Combinational fixed-priority pick: one-hot winner of req, HIGH_PRIO_IDX first.
module priority_arb_2bit_pick
    import priority_arb_2bit_pkg::*;
#(
    parameter int HIGH_PRIO_IDX = 0
) (
    input  req_vec_t req,
    output req_vec_t next_grant
);

    localparam logic HI_IDX = HIGH_PRIO_IDX[0];
    localparam logic LO_IDX = ~HI_IDX;

    always_comb begin
        next_grant = '0;
        if (req[HI_IDX]) begin
            next_grant[HI_IDX] = 1'b1;
        end else if (req[LO_IDX]) begin
            next_grant[LO_IDX] = 1'b1;
        end
    end

endmodule

// File: rtl/priority_arb_2bit.sv
// Two-requester fixed-priority arbiter with registered one-hot grant.
// Define PRIORITY_ARB_2BIT_LOCK_EN for non-preemptive lock mode.
module priority_arb_2bit
    import priority_arb_2bit_pkg::*;
#(
    parameter int HIGH_PRIO_IDX = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req,
    output req_vec_t grant,
    output logic     grant_valid,
    output logic     grant_id
);

    generate
        if (HIGH_PRIO_IDX != 0 && HIGH_PRIO_IDX != 1) begin : g_bad_prio
            $error("priority_arb_2bit: HIGH_PRIO_IDX must be 0 or 1");
        end
    endgenerate

    req_vec_t pick_grant;
    req_vec_t next_grant;

    priority_arb_2bit_pick #(
        .HIGH_PRIO_IDX(HIGH_PRIO_IDX)
    ) u_pick (
        .req        (req),
        .next_grant (pick_grant)
    );

`ifdef PRIORITY_ARB_2BIT_LOCK_EN
    logic locked_q;

    // Current holder keeps the grant while it still requests.
    always_comb begin
        next_grant = pick_grant;
        if (locked_q && req[grant_id]) begin
            next_grant = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= |next_grant;
        end
    end
`else
    assign next_grant = pick_grant;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= 1'b0;
        end else begin
            grant       <= next_grant;
            grant_valid <= |next_grant;
            grant_id    <= onehot_to_idx(next_grant);
        end
    end

endmodule

// File: tb/tb_priority_arb_2bit.sv
// Self-checking bench: both priority orders side by side against a reference model.
module tb_priority_arb_2bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] grant0, grant1;
    logic       valid0, valid1;
    logic       id0, id1;

    int unsigned n_checks;
    int unsigned n_errors;

    // Model state: expected registered grant for each priority order.
    logic [1:0] exp_g0, exp_g1;

    priority_arb_2bit #(.HIGH_PRIO_IDX(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant0),
        .grant_valid (valid0),
        .grant_id    (id0)
    );

    priority_arb_2bit #(.HIGH_PRIO_IDX(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant1),
        .grant_valid (valid1),
        .grant_id    (id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: rank requesters by priority, honour a still-requesting holder in lock mode.
    function automatic logic [1:0] model(input int hi, input logic [1:0] r, input logic [1:0] prev);
        int order[2];
        logic [1:0] res;
        order[0] = hi;
        order[1] = 1 - hi;
`ifdef PRIORITY_ARB_2BIT_LOCK_EN
        for (int k = 0; k < 2; k++) begin
            if (prev == (2'b01 << k) && r[k]) return prev;
        end
`endif
        res = 2'b00;
        for (int k = 1; k >= 0; k--) begin
            if (r[order[k]]) res = 2'b01 << order[k];
        end
        return res;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".g0"},  32'(grant0), 32'(exp_g0));
        check({tag, ".v0"},  32'(valid0), 32'(exp_g0 != 2'b00));
        check({tag, ".id0"}, 32'(id0),    32'(exp_g0 == 2'b10));
        check({tag, ".g1"},  32'(grant1), 32'(exp_g1));
        check({tag, ".v1"},  32'(valid1), 32'(exp_g1 != 2'b00));
        check({tag, ".id1"}, 32'(id1),    32'(exp_g1 == 2'b10));
        check({tag, ".inv"}, 32'((grant0 == 2'b11) || (grant1 == 2'b11)), 32'd0);
    endtask

    // Apply req at the falling edge, let one rising edge sample it, check just after.
    task automatic step(input logic [1:0] r, input string tag);
        @(negedge clk);
        req = r;
        @(posedge clk);
        exp_g0 = model(0, r, exp_g0);
        exp_g1 = model(1, r, exp_g1);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_g0 = 2'b00;
        exp_g1 = 2'b00;
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        check_outputs({tag, ".hold"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        req      = 2'b00;
        exp_g0   = 2'b00;
        exp_g1   = 2'b00;

        do_reset("por");

        // Get a grant in flight, then reset asynchronously with req=11 held.
        step(2'b11, "pre_rst");
        req = 2'b11;
        do_reset("rst_mid");

        step(2'b00, "single00");
        step(2'b01, "single01");
        step(2'b10, "single10");
        step(2'b11, "contend");

        step(2'b00, "idle");
        step(2'b10, "pre_a");
        step(2'b10, "pre_b");
        step(2'b11, "pre_c");
        step(2'b11, "pre_d");

        step(2'b00, "idle2");
        step(2'b10, "lock_a");
        step(2'b11, "lock_b");
        step(2'b11, "lock_c");
        step(2'b11, "lock_d");
        step(2'b01, "lock_e");
        step(2'b01, "lock_f");

        step(2'b01, "hand_a");
        step(2'b10, "hand_b");
        step(2'b01, "hand_c");
        step(2'b00, "hand_d");

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                req = 2'b11;
                do_reset("rst_rand");
            end
            step(2'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
